// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end that shares one add_sub_fp unit among NumReq requesters.
// Resolves dynamic rounding, sequences start/done with a watchdog, and accumulates fflags.
module fp_addsub_arbiter #(
    parameter int unsigned Size          = 64,
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TagWidth      = 4,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NumReq-1:0]                                 req_valid,
    output logic [NumReq-1:0]                                 req_ready,
    input  logic [NumReq*Size-1:0]                            req_a,
    input  logic [NumReq*Size-1:0]                            req_b,
    input  logic [NumReq-1:0]                                 req_sub,
    input  logic [NumReq*3-1:0]                               req_rm,
    input  logic [NumReq*TagWidth-1:0]                        req_tag,
    input  logic [2:0]                                        frm,
    output logic                                              resp_valid,
    input  logic                                              resp_ready,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0]    resp_id,
    output logic [TagWidth-1:0]                               resp_tag,
    output logic [Size-1:0]                                   resp_result,
    output logic [4:0]                                        resp_flags,
    output logic                                              resp_error,
    output logic [4:0]                                        fflags_acc,
    input  logic                                              fflags_clear,
    output logic                                              busy,
    output logic                                              fpu_start,
    output logic                                              fpu_sub,
    output logic [2:0]                                        fpu_rm,
    output logic [Size-1:0]                                   fpu_a,
    output logic [Size-1:0]                                   fpu_b,
    input  logic [Size-1:0]                                   fpu_result,
    input  logic                                              fpu_invalid,
    input  logic                                              fpu_overflow,
    input  logic                                              fpu_underflow,
    input  logic                                              fpu_inexact,
    input  logic                                              fpu_done
);

    localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
    localparam logic [IdW-1:0] IdLast = IdW'(NumReq - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [Size-1:0]      a_q, a_d;
    logic [Size-1:0]      b_q, b_d;
    logic                 sub_q, sub_d;
    logic [2:0]           rm_q, rm_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic [IdW-1:0]       id_q, id_d;
    logic [Size-1:0]      result_q, result_d;
    logic [4:0]           flags_q, flags_d;
    logic                 error_q, error_d;
    logic [WdW-1:0]       wdog_q, wdog_d;
    logic [4:0]           fflags_q, fflags_d;

    logic                 win_found;
    logic [IdW-1:0]       win_idx;
    logic [IdW-1:0]       cand_id;
    int unsigned          cand;
    logic                 hs_req;
    logic [2:0]           rm_req;
    logic [2:0]           rm_eff;
    logic                 rm_bad;

    // Search starts at the round-robin pointer and wraps; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_id   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_id = cand[IdW-1:0];
            if (!win_found && req_valid[cand_id]) begin
                win_found = 1'b1;
                win_idx   = cand_id;
            end
        end
    end

    always_comb begin
        hs_req    = (state_q == S_IDLE) && win_found && !reset;
        req_ready = '0;
        if (hs_req) begin
            req_ready[win_idx] = 1'b1;
        end
        rm_req = req_rm[win_idx*3 +: 3];
        rm_eff = (rm_req == 3'b111) ? frm : rm_req;
        rm_bad = (rm_eff > 3'b100);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        rm_d     = rm_q;
        tag_d    = tag_q;
        id_d     = id_q;
        result_d = result_q;
        flags_d  = flags_q;
        error_d  = error_q;
        wdog_d   = wdog_q;
        // Clear applies before any same-cycle accumulate.
        fflags_d = fflags_clear ? '0 : fflags_q;

        case (state_q)
            S_IDLE: begin
                if (hs_req) begin
                    a_d      = req_a[win_idx*Size +: Size];
                    b_d      = req_b[win_idx*Size +: Size];
                    sub_d    = req_sub[win_idx];
                    rm_d     = rm_eff;
                    tag_d    = req_tag[win_idx*TagWidth +: TagWidth];
                    id_d     = win_idx;
                    ptr_d    = (win_idx == IdLast) ? '0 : win_idx + 1'b1;
                    result_d = '0;
                    flags_d  = '0;
                    error_d  = rm_bad;
                    state_d  = rm_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done) begin
                    result_d = fpu_result;
                    flags_d  = {fpu_invalid, 1'b0, fpu_overflow, fpu_underflow, fpu_inexact};
                    state_d  = S_RESP;
                end else if (wdog_q == WdLast) begin
                    result_d = '0;
                    flags_d  = '0;
                    error_d  = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (!error_q) begin
                        fflags_d = fflags_d | flags_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            rm_q     <= '0;
            tag_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            error_q  <= 1'b0;
            wdog_q   <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            rm_q     <= rm_d;
            tag_q    <= tag_d;
            id_q     <= id_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            error_q  <= error_d;
            wdog_q   <= wdog_d;
            fflags_q <= fflags_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign fpu_start   = (state_q == S_ISSUE);
    assign resp_valid  = (state_q == S_RESP);
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_sub     = sub_q;
    assign fpu_rm      = rm_q;
    assign resp_id     = id_q;
    assign resp_tag    = tag_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign resp_error  = error_q;
    assign fflags_acc  = fflags_q;

endmodule
